// File: rtl/button_bank_handler_if.sv
// Button bank signal bundle: raw button levels in, debounced levels and event pulses out.
interface button_bank_handler_if #(
  parameter int N_BTN = 2
);
  logic [N_BTN-1:0] button;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] press_pulse;
  logic [N_BTN-1:0] release_pulse;
  logic [N_BTN-1:0] long_pulse;
  logic [N_BTN-1:0] repeat_pulse;
  logic             any_press;

  modport slave (
    input  button,
    output btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_press
  );
  modport master (
    output button,
    input  btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_press
  );
endinterface

// File: rtl/button_bank_handler.sv
// N_BTN-channel pushbutton front end: sync, debounce, press/release/long pulses.
// Optional auto-repeat pulses are built only when BTN_AUTOREPEAT_EN is defined.
module button_bank_lane #(
  parameter int SYNC_STAGES     = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level_o,
  output logic press_o,
  output logic rel_o,
  output logic long_o,
  output logic rpt_o,
  output logic press_nxt_o
);
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cfg
    $error("button_bank_lane: illegal parameter value");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic level_q, level_d, lvl_dly_q, lvl_dly_d;
  logic press_q, press_d, rel_q, rel_d, long_q, long_d;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], raw};
    db_cnt_d  = db_cnt_q;
    level_d   = level_q;
    if (sync_q[SYNC_STAGES-1] == level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      level_d  = ~level_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
    lvl_dly_d = level_q;
    press_d   = level_q & ~lvl_dly_q;
    rel_d     = ~level_q & lvl_dly_q;
    // Hold counter saturates at LONG_CYCLES so long_pulse fires once per press.
    hold_d    = hold_q;
    if (!level_q || press_d) hold_d = '0;
    else if (hold_q != HOLD_W'(LONG_CYCLES)) hold_d = hold_q + 1'b1;
    long_d    = level_q & ~press_d & (hold_q == HOLD_W'(LONG_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      db_cnt_q  <= '0;
      hold_q    <= '0;
      level_q   <= 1'b0;
      lvl_dly_q <= 1'b0;
      press_q   <= 1'b0;
      rel_q     <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      db_cnt_q  <= db_cnt_d;
      hold_q    <= hold_d;
      level_q   <= level_d;
      lvl_dly_q <= lvl_dly_d;
      press_q   <= press_d;
      rel_q     <= rel_d;
      long_q    <= long_d;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic rpt_act_q, rpt_act_d, rpt_q, rpt_d;

  always_comb begin
    rpt_cnt_d = rpt_cnt_q;
    rpt_act_d = rpt_act_q;
    rpt_d     = 1'b0;
    if (!level_q) begin
      rpt_cnt_d = '0;
      rpt_act_d = 1'b0;
    end else if (long_d) begin
      rpt_cnt_d = '0;
      rpt_act_d = 1'b1;
    end else if (rpt_act_q) begin
      if (rpt_cnt_q == RPT_W'(REPEAT_CYCLES - 1)) begin
        rpt_d     = 1'b1;
        rpt_cnt_d = '0;
      end else begin
        rpt_cnt_d = rpt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_cnt_q <= '0;
      rpt_act_q <= 1'b0;
      rpt_q     <= 1'b0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
      rpt_act_q <= rpt_act_d;
      rpt_q     <= rpt_d;
    end
  end

  assign rpt_o = rpt_q;
`else
  assign rpt_o = 1'b0;
`endif

  assign level_o     = level_q;
  assign press_o     = press_q;
  assign rel_o       = rel_q;
  assign long_o      = long_q;
  assign press_nxt_o = press_d;
endmodule

module button_bank_handler #(
  parameter int N_BTN           = 2,
  parameter int SYNC_STAGES     = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input logic                  clk_100,
  input logic                  s_rst,
  button_bank_handler_if.slave bus
);
  logic [N_BTN-1:0] lvl, prs, rel, lng, rpt, prs_nxt;
  logic any_press_q, any_press_d;

  for (genvar g = 0; g < N_BTN; g++) begin : g_lane
    button_bank_lane #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_lane (
      .clk        (clk_100),
      .rst        (s_rst),
      .raw        (bus.button[g]),
      .level_o    (lvl[g]),
      .press_o    (prs[g]),
      .rel_o      (rel[g]),
      .long_o     (lng[g]),
      .rpt_o      (rpt[g]),
      .press_nxt_o(prs_nxt[g])
    );
  end

  // Registered from the lanes' next-state press terms so it aligns with press_pulse.
  always_comb any_press_d = |prs_nxt;

  always_ff @(posedge clk_100) begin
    if (s_rst) any_press_q <= 1'b0;
    else       any_press_q <= any_press_d;
  end

  assign bus.btn_level     = lvl;
  assign bus.press_pulse   = prs;
  assign bus.release_pulse = rel;
  assign bus.long_pulse    = lng;
  assign bus.repeat_pulse  = rpt;
  assign bus.any_press     = any_press_q;
endmodule

// File: tb/tb_button_bank_handler.sv
// Scoreboard bench for button_bank_handler: timestamp-based reference model, random + directed stimulus.
module tb_button_bank_handler;
  localparam int N = 4, S = 3, D = 4, L = 20, R = 5, MAXE = 8192;

  logic clk_100 = 1'b0;
  logic s_rst;
  always #5 clk_100 = ~clk_100;

  button_bank_handler_if #(.N_BTN(N)) bus ();

  button_bank_handler #(
    .N_BTN(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .REPEAT_CYCLES(R)
  ) dut (
    .clk_100(clk_100),
    .s_rst  (s_rst),
    .bus    (bus)
  );

  typedef struct packed {
    logic [N-1:0] lvl, prs, rel, lng, rpt;
    logic         any;
  } obs_t;

  obs_t exp_q[$];
  int checks = 0, errors = 0;

  logic [N-1:0] samp_h [MAXE];
  logic [N-1:0] lvl_h  [MAXE];
  int  n = 0, last_rst = 0;
  bit  started = 0;
  int  press_t [N];
  int  long_t  [N];

  // Level flips when the synchronised input has disagreed with it for the last D edges since reset.
  task automatic model_step();
    obs_t e;
    logic old, s, flip, p1, p2;
    e = '0;
    if (s_rst) begin
      started = 1; n++; last_rst = n;
      samp_h[n] = '0; lvl_h[n] = '0;
      for (int ch = 0; ch < N; ch++) begin press_t[ch] = -1; long_t[ch] = -1; end
      exp_q.push_back(e);
      return;
    end
    if (!started || n >= MAXE - 1) return;
    n++;
    samp_h[n] = bus.button;
    lvl_h[n]  = lvl_h[n-1];
    for (int ch = 0; ch < N; ch++) begin
      old  = lvl_h[n-1][ch];
      flip = 1'b1;
      for (int k = 0; k < D; k++) begin
        int ev;
        ev = n - k;
        if (ev <= last_rst) flip = 1'b0;
        else begin
          s = (ev - S > last_rst) ? samp_h[ev-S][ch] : 1'b0;
          if (s == old) flip = 1'b0;
        end
      end
      lvl_h[n][ch] = flip ? ~old : old;
      p1 = lvl_h[n-1][ch];
      p2 = (n - 1 == last_rst) ? 1'b0 : lvl_h[n-2][ch];
      e.lvl[ch] = lvl_h[n][ch];
      e.prs[ch] = p1 & ~p2;
      e.rel[ch] = ~p1 & p2;
      if (e.prs[ch]) begin press_t[ch] = n; long_t[ch] = -1; end
      if (p1 && press_t[ch] > 0 && n - press_t[ch] == L) begin
        e.lng[ch] = 1'b1; long_t[ch] = n;
      end
`ifdef BTN_AUTOREPEAT_EN
      if (p1 && long_t[ch] > 0 && n > long_t[ch] && (n - long_t[ch]) % R == 0) e.rpt[ch] = 1'b1;
`endif
    end
    e.any = |e.prs;
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk_100);
    model_step();
  end

  task automatic chk(input string nm, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %b expected %b", nm, n, got, exp);
    end
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(negedge clk_100);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("btn_level",     bus.btn_level,     e.lvl);
        chk("press_pulse",   bus.press_pulse,   e.prs);
        chk("release_pulse", bus.release_pulse, e.rel);
        chk("long_pulse",    bus.long_pulse,    e.lng);
        chk("repeat_pulse",  bus.repeat_pulse,  e.rpt);
        chk("any_press",     N'(bus.any_press), N'(e.any));
      end
    end
  end

  task automatic drive(input logic [N-1:0] b, input logic r, input int cyc);
    for (int i = 0; i < cyc; i++) begin
      bus.button = b;
      s_rst      = r;
      @(negedge clk_100);
    end
  endtask

  initial begin : stim
    int run [N];
    logic [N-1:0] cur;
    s_rst = 1'b1;
    bus.button = '0;
    drive(4'b0000, 1'b1, 3);
    drive(4'b0000, 1'b0, 5);
    drive(4'b0001, 1'b0, 30);   // clean press
    drive(4'b0011, 1'b0, 3);    // 3-cycle glitch on ch1
    drive(4'b0001, 1'b0, 10);
    drive(4'b0000, 1'b0, 12);
    drive(4'b0100, 1'b0, 75);   // long press
    drive(4'b0000, 1'b0, 15);
    drive(4'b1000, 1'b0, 75);   // long + auto-repeat
    drive(4'b0000, 1'b0, 15);
    drive(4'b1111, 1'b0, 15);   // simultaneous
    drive(4'b1111, 1'b1, 1);    // reset while held
    drive(4'b1111, 1'b0, 15);
    drive(4'b0000, 1'b0, 15);
    drive(4'b0001, 1'b0, 20);   // release lands on long_pulse cycle
    drive(4'b0000, 1'b0, 20);
    cur = '0;
    for (int ch = 0; ch < N; ch++) run[ch] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int ch = 0; ch < N; ch++) begin
        if (run[ch] == 0) begin
          cur[ch] = ~cur[ch];
          run[ch] = $urandom_range(1, 45);
        end else run[ch]--;
      end
      drive(cur, ($urandom_range(0, 299) == 0), 1);
    end
    drive(4'b0000, 1'b0, 10);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
